// File: rtl/sdio_init_pkg.sv
// sdio_init_pkg: shared definitions for the SD card bring-up sequencer.
//   Command indices, response-type and error-code enums, CMD8 check pattern,
//   OCR voltage window and the ACMD41 argument builder.
package sdio_init_pkg;

    localparam logic [5:0] Cmd0   = 6'd0;
    localparam logic [5:0] Cmd2   = 6'd2;
    localparam logic [5:0] Cmd3   = 6'd3;
    localparam logic [5:0] Cmd7   = 6'd7;
    localparam logic [5:0] Cmd8   = 6'd8;
    localparam logic [5:0] Cmd55  = 6'd55;
    localparam logic [5:0] Acmd6  = 6'd6;
    localparam logic [5:0] Acmd41 = 6'd41;

    localparam logic [11:0] Cmd8Check = 12'h1AA;
    localparam logic [23:0] OcrWindow = 24'hFF8000;
    localparam logic [31:0] Cmd8Arg   = {20'h0, Cmd8Check};
    localparam logic [31:0] Acmd6Arg  = 32'h2;

    typedef enum logic [1:0] {
        RtNone = 2'd0,
        RtR1   = 2'd1,
        RtR2   = 2'd2,
        RtR3   = 2'd3
    } rtype_e;

    typedef enum logic [2:0] {
        ErrNone      = 3'd0,
        ErrCmd0Cmd2  = 3'd1,
        ErrAcmd41Tmo = 3'd2,
        ErrCmd8Echo  = 3'd3,
        ErrCmd3Cmd7  = 3'd4,
        ErrAcmd6     = 3'd5
    } err_e;

    // ACMD41 argument: HCS request in bit 30, voltage window in [23:0].
    function automatic logic [31:0] acmd41_arg(input logic hcs);
        return {1'b0, hcs, 6'h0, OcrWindow};
    endfunction

endpackage

// File: rtl/sdio_init_seq_if.sv
// sdio_init_seq_if: command/response channel between the init sequencer and the
// host command engine.
//   cmd_valid/cmd_ready  command handshake (valid && ready = issued)
//   cmd_idx/arg/rtype    command fields, stable while cmd_valid is high
//   rsp_valid/err/data   one response per issued command
// Modports: master = sequencer side, slave = command engine side.
interface sdio_init_seq_if;
    import sdio_init_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    rtype_e      cmd_rtype;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;

    modport master (
        output cmd_valid, cmd_idx, cmd_arg, cmd_rtype,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_idx, cmd_arg, cmd_rtype,
        output cmd_ready, rsp_valid, rsp_err, rsp_data
    );

endinterface

// File: rtl/sdio_init_timer.sv
// sdio_init_timer: loadable down-counter used for the power-up and poll-gap waits.
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_load, i_value   load the counter with i_value
//   o_zero            counter has reached zero (it stops there, no wrap)
module sdio_init_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/sdio_init_seq.sv
// sdio_init_seq: host-side SD card bring-up sequencer.
//   Drives the command engine through CMD0, CMD8, (CMD55+ACMD41)*, CMD2, CMD3, CMD7
//   and, when SDIO_INIT_WIDE_EN is defined, CMD55+ACMD6 to switch to a 4-bit bus.
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_start, i_abort      begin init (ignored while busy) / abandon to IDLE
//   o_busy                sequence in progress
//   o_done, o_fail        one-cycle result pulses; o_err_code valid with o_fail
//   cmd_if                command/response channel (master side)
//   o_rca, o_ccs, o_wide  captured RCA, card capacity status, 4-bit bus active
// Build option: SDIO_INIT_WIDE_EN enables the ACMD6 bus-width step.
module sdio_init_seq
    import sdio_init_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES = 80,
    parameter int unsigned MAX_POLLS    = 1000,
    parameter int unsigned POLL_GAP     = 1024,
    parameter bit          OPT_HCS      = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_fail,
    output logic [2:0]             o_err_code,
    sdio_init_seq_if.master        cmd_if,
    output logic [15:0]            o_rca,
    output logic                   o_ccs,
    output logic                   o_wide
);

    localparam int unsigned TimerMax = (PWRUP_CYCLES > POLL_GAP) ? PWRUP_CYCLES : POLL_GAP;
    localparam int unsigned TimerW   = (TimerMax < 1) ? 1 : $clog2(TimerMax + 1);
    localparam int unsigned PollW    = (MAX_POLLS < 1) ? 1 : $clog2(MAX_POLLS + 1);

    typedef enum logic [3:0] {
        StIdle, StPwrup, StCmd0, StCmd8, StA55, StA41, StGap,
        StCmd2, StCmd3, StCmd7, StW55, StAcmd6
    } state_e;

    state_e             state_q, state_d;
    logic               wait_q, wait_d;     // issued command awaiting its response
    logic [1:0]         drain_q, drain_d;   // responses still owed for abandoned commands
    logic               v2_q, v2_d;
    logic [PollW-1:0]   poll_q, poll_d;
    logic [1:0]         tries_q, tries_d;
    logic [15:0]        rca_q, rca_d;
    logic               ccs_q, ccs_d;
    err_e               err_q, err_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;

    logic               is_cmd;
    logic               cmd_valid;
    logic [5:0]         cmd_idx;
    logic [31:0]        cmd_arg;
    rtype_e             cmd_rtype;
    logic               cmd_accept;
    logic               rsp_stale;
    logic               rsp_take;
    logic               go_poll, go_fail, go_done;
    err_e               fail_code;
    logic               tmr_load, tmr_zero;
    logic [TimerW-1:0]  tmr_value;
    logic               unused_rsp;

    sdio_init_timer #(
        .WIDTH (TimerW)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (tmr_load),
        .i_value   (tmr_value),
        .o_zero    (tmr_zero)
    );

    // Command fields decode purely from the state so they hold until acceptance.
    always_comb begin
        is_cmd    = 1'b1;
        cmd_idx   = Cmd0;
        cmd_arg   = 32'h0;
        cmd_rtype = RtNone;
        case (state_q)
            StCmd0:  ;
            StCmd8:  begin cmd_idx = Cmd8;   cmd_arg = Cmd8Arg;            cmd_rtype = RtR1; end
            StA55:   begin cmd_idx = Cmd55;  cmd_arg = {rca_q, 16'h0};     cmd_rtype = RtR1; end
            StA41:   begin
                cmd_idx   = Acmd41;
                cmd_arg   = acmd41_arg(OPT_HCS && v2_q);
                cmd_rtype = RtR3;
            end
            StCmd2:  begin cmd_idx = Cmd2;                                 cmd_rtype = RtR2; end
            StCmd3:  begin cmd_idx = Cmd3;                                 cmd_rtype = RtR1; end
            StCmd7:  begin cmd_idx = Cmd7;   cmd_arg = {rca_q, 16'h0};     cmd_rtype = RtR1; end
`ifdef SDIO_INIT_WIDE_EN
            StW55:   begin cmd_idx = Cmd55;  cmd_arg = {rca_q, 16'h0};     cmd_rtype = RtR1; end
            StAcmd6: begin cmd_idx = Acmd6;  cmd_arg = Acmd6Arg;           cmd_rtype = RtR1; end
`endif
            default: is_cmd = 1'b0;
        endcase
    end

    assign cmd_valid  = is_cmd && !wait_q;
    assign cmd_accept = cmd_valid && cmd_if.cmd_ready;
    // Responses are strictly ordered, so owed responses of abandoned commands come first.
    assign rsp_stale  = cmd_if.rsp_valid && (drain_q != 2'd0);
    assign rsp_take   = cmd_if.rsp_valid && (drain_q == 2'd0) && wait_q;

`ifdef SDIO_INIT_WIDE_EN
    logic wide_q, wide_d;
`endif

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        drain_d   = drain_q;
        v2_d      = v2_q;
        poll_d    = poll_q;
        tries_d   = tries_q;
        rca_d     = rca_q;
        ccs_d     = ccs_q;
        err_d     = err_q;
        done_d    = 1'b0;
        fail_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = TimerW'(PWRUP_CYCLES);
        go_poll   = 1'b0;
        go_fail   = 1'b0;
        go_done   = 1'b0;
        fail_code = ErrNone;
`ifdef SDIO_INIT_WIDE_EN
        wide_d    = wide_q;
`endif
        if (rsp_stale) begin
            drain_d = drain_q - 2'd1;
        end

        if (i_abort) begin
            state_d = StIdle;
            wait_d  = 1'b0;
            if ((wait_q && !rsp_take) || cmd_accept) begin
                drain_d = drain_d + 2'd1;
            end
        end else begin
            if (cmd_accept) wait_d = 1'b1;
            if (rsp_take)   wait_d = 1'b0;

            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_d  = StPwrup;
                        tmr_load = 1'b1;
                        v2_d     = 1'b0;
                        poll_d   = '0;
                        tries_d  = 2'd0;
                        rca_d    = 16'h0;
                        ccs_d    = 1'b0;
                        err_d    = ErrNone;
`ifdef SDIO_INIT_WIDE_EN
                        wide_d   = 1'b0;
`endif
                    end
                end
                StPwrup: if (tmr_zero) state_d = StCmd0;
                StGap:   if (tmr_zero) state_d = StA55;
                StCmd0: if (rsp_take) begin
                    if (cmd_if.rsp_err) begin go_fail = 1'b1; fail_code = ErrCmd0Cmd2; end
                    else                       state_d = StCmd8;
                end
                StCmd8: if (rsp_take) begin
                    if (cmd_if.rsp_err) begin
                        v2_d    = 1'b0;      // no CMD8 response: v1 card
                        state_d = StA55;
                    end else if (cmd_if.rsp_data[11:0] != Cmd8Check) begin
                        go_fail   = 1'b1;
                        fail_code = ErrCmd8Echo;
                    end else begin
                        v2_d    = 1'b1;
                        state_d = StA55;
                    end
                end
                StA55: if (rsp_take) begin
                    if (cmd_if.rsp_err) go_poll = 1'b1;
                    else                state_d = StA41;
                end
                StA41: if (rsp_take) begin
                    if (cmd_if.rsp_err || !cmd_if.rsp_data[31]) begin
                        go_poll = 1'b1;
                    end else begin
                        ccs_d   = cmd_if.rsp_data[30];
                        state_d = StCmd2;
                    end
                end
                StCmd2: if (rsp_take) begin
                    if (cmd_if.rsp_err) begin go_fail = 1'b1; fail_code = ErrCmd0Cmd2; end
                    else                       state_d = StCmd3;
                end
                StCmd3: if (rsp_take) begin
                    if (cmd_if.rsp_err) begin
                        go_fail   = 1'b1;
                        fail_code = ErrCmd3Cmd7;
                    end else begin
                        rca_d = cmd_if.rsp_data[31:16];
                        if (cmd_if.rsp_data[31:16] != 16'h0) begin
                            state_d = StCmd7;
                        end else if (tries_q == 2'd2) begin
                            go_fail   = 1'b1;
                            fail_code = ErrCmd3Cmd7;
                        end else begin
                            tries_d = tries_q + 2'd1;   // stay: CMD3 is reissued
                        end
                    end
                end
                StCmd7: if (rsp_take) begin
                    if (cmd_if.rsp_err) begin
                        go_fail   = 1'b1;
                        fail_code = ErrCmd3Cmd7;
                    end else begin
`ifdef SDIO_INIT_WIDE_EN
                        state_d = StW55;
`else
                        go_done = 1'b1;
`endif
                    end
                end
`ifdef SDIO_INIT_WIDE_EN
                StW55: if (rsp_take) begin
                    if (cmd_if.rsp_err) begin go_fail = 1'b1; fail_code = ErrAcmd6; end
                    else                       state_d = StAcmd6;
                end
                StAcmd6: if (rsp_take) begin
                    if (cmd_if.rsp_err) begin
                        go_fail   = 1'b1;
                        fail_code = ErrAcmd6;
                    end else begin
                        wide_d  = 1'b1;
                        go_done = 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase

            // A failed ACMD41 round (busy or any error) counts as one poll.
            if (go_poll) begin
                if ((32'(poll_q) + 32'd1) >= MAX_POLLS) begin
                    go_fail   = 1'b1;
                    fail_code = ErrAcmd41Tmo;
                end else begin
                    poll_d    = poll_q + PollW'(1);
                    state_d   = StGap;
                    tmr_load  = 1'b1;
                    tmr_value = TimerW'(POLL_GAP);
                end
            end
            if (go_fail) begin
                fail_d  = 1'b1;
                err_d   = fail_code;
                state_d = StIdle;
            end
            if (go_done) begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            wait_q  <= 1'b0;
            drain_q <= 2'd0;
            v2_q    <= 1'b0;
            poll_q  <= '0;
            tries_q <= 2'd0;
            rca_q   <= 16'h0;
            ccs_q   <= 1'b0;
            err_q   <= ErrNone;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            v2_q    <= v2_d;
            poll_q  <= poll_d;
            tries_q <= tries_d;
            rca_q   <= rca_d;
            ccs_q   <= ccs_d;
            err_q   <= err_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

`ifdef SDIO_INIT_WIDE_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) wide_q <= 1'b0;
        else            wide_q <= wide_d;
    end
    assign o_wide = wide_q;
`else
    assign o_wide = 1'b0;
`endif

    assign cmd_if.cmd_valid = cmd_valid;
    assign cmd_if.cmd_idx   = cmd_idx;
    assign cmd_if.cmd_arg   = cmd_arg;
    assign cmd_if.cmd_rtype = cmd_rtype;

    assign o_busy     = (state_q != StIdle);
    assign o_done     = done_q;
    assign o_fail     = fail_q;
    assign o_err_code = err_q;
    assign o_rca      = rca_q;
    assign o_ccs      = ccs_q;

    assign unused_rsp = ^cmd_if.rsp_data[15:12];

endmodule
